// File: rtl/vga_square_ctrl.sv
// Frame-synchronous square-overlay bounds controller: host writes shadow bounds, commit copies them to live at vblank.
// Optional build macro VGA_SQUARE_BOUNCE_EN: live box bounces STEP px per frame while idle.
module vga_square_ctrl #(
  parameter int CORDW   = 10,
  parameter int G_H_RES = 640,
  parameter int G_V_RES = 480,
  parameter int DEF_X0  = 220,
  parameter int DEF_Y0  = 140,
  parameter int DEF_X1  = 420,
  parameter int DEF_Y1  = 340,
  parameter int STEP    = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CORDW-1:0] i_x,
  input  logic [CORDW-1:0] i_y,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [1:0]       i_wr_addr,
  input  logic [CORDW-1:0] i_wr_data,
  input  logic             i_commit,
  output logic             o_pending,
  output logic             o_committed,
  output logic             o_err,
  output logic [CORDW-1:0] o_x0,
  output logic [CORDW-1:0] o_y0,
  output logic [CORDW-1:0] o_x1,
  output logic [CORDW-1:0] o_y1,
  output logic             o_square
);
  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_COMMIT} state_t;

  // Box index order: 0=X0 1=Y0 2=X1 3=Y1, matching the host address map
  localparam logic [3:0][CORDW-1:0] DEF_BOX =
    {CORDW'(DEF_Y1), CORDW'(DEF_X1), CORDW'(DEF_Y0), CORDW'(DEF_X0)};

  if (DEF_X0 >= DEF_X1 || DEF_Y0 >= DEF_Y1 || DEF_X1 >= G_H_RES ||
      DEF_Y1 >= G_V_RES || STEP < 1) begin : g_bad_params
    $error("vga_square_ctrl: inconsistent parameters");
  end

  state_t                  state;
  logic [3:0][CORDW-1:0]   shadow, shadow_nxt, live;
  logic                    wr_fire, shadow_ok, vbl_start;

  assign wr_fire   = i_wr_valid && o_wr_ready;
  assign vbl_start = (i_x == '0) && (i_y == CORDW'(G_V_RES));

  // Validity is judged on the shadow as it will be after this cycle's write
  always_comb begin
    shadow_nxt = shadow;
    if (wr_fire) shadow_nxt[i_wr_addr] = i_wr_data;
  end
  assign shadow_ok = (shadow_nxt[0] < shadow_nxt[2]) && (shadow_nxt[1] < shadow_nxt[3]);

  assign o_x0 = live[0];
  assign o_y0 = live[1];
  assign o_x1 = live[2];
  assign o_y1 = live[3];

`ifdef VGA_SQUARE_BOUNCE_EN
  localparam logic [CORDW:0]   STEP_W = (CORDW+1)'(STEP);
  localparam logic [CORDW-1:0] STEP_C = CORDW'(STEP);

  logic                  dir_x, dir_y;  // 1 = moving toward zero
  logic                  neg_x, neg_y;
  logic [3:0][CORDW-1:0] live_mv;

  // Direction flips in the same frame the edge would be crossed
  always_comb begin
    neg_x = dir_x ? ({1'b0, live[0]} >= STEP_W)
                  : (({1'b0, live[2]} + STEP_W) > (CORDW+1)'(G_H_RES-1));
    neg_y = dir_y ? ({1'b0, live[1]} >= STEP_W)
                  : (({1'b0, live[3]} + STEP_W) > (CORDW+1)'(G_V_RES-1));
    live_mv[0] = neg_x ? live[0] - STEP_C : live[0] + STEP_C;
    live_mv[2] = neg_x ? live[2] - STEP_C : live[2] + STEP_C;
    live_mv[1] = neg_y ? live[1] - STEP_C : live[1] + STEP_C;
    live_mv[3] = neg_y ? live[3] - STEP_C : live[3] + STEP_C;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      shadow      <= DEF_BOX;
      live        <= DEF_BOX;
      o_wr_ready  <= 1'b1;
      o_pending   <= 1'b0;
      o_committed <= 1'b0;
      o_err       <= 1'b0;
      o_square    <= 1'b0;
`ifdef VGA_SQUARE_BOUNCE_EN
      dir_x       <= 1'b0;
      dir_y       <= 1'b0;
`endif
    end else begin
      o_committed <= 1'b0;
      o_err       <= 1'b0;
      o_square    <= (i_x > live[0]) && (i_x < live[2]) &&
                     (i_y > live[1]) && (i_y < live[3]);
      shadow      <= shadow_nxt;
      case (state)
        S_IDLE: begin
          if (i_commit && shadow_ok) begin
            state      <= vbl_start ? S_COMMIT : S_PENDING;
            o_pending  <= !vbl_start;
            o_wr_ready <= 1'b0;
          end else begin
            if (i_commit) o_err <= 1'b1;
`ifdef VGA_SQUARE_BOUNCE_EN
            if (vbl_start) begin
              live  <= live_mv;
              dir_x <= neg_x;
              dir_y <= neg_y;
            end
`endif
          end
        end
        S_PENDING: begin
          if (vbl_start) begin
            state     <= S_COMMIT;
            o_pending <= 1'b0;
          end
        end
        S_COMMIT: begin
          live        <= shadow;
          o_committed <= 1'b1;
          o_wr_ready  <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          o_pending  <= 1'b0;
          o_wr_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_square_ctrl.sv
// Scoreboard bench for vga_square_ctrl: timed level checks plus a pulse-event queue.
module tb_vga_square_ctrl;
  localparam int CORDW = 10;
  localparam int K_SQ = 0, K_PEND = 1, K_RDY = 2, K_X0 = 3, K_Y0 = 4, K_X1 = 5, K_Y1 = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [CORDW-1:0] ix, iy, wr_data;
  logic             wr_valid, commit;
  logic [1:0]       wr_addr;
  logic             wr_ready, pending, committed, err, square;
  logic [CORDW-1:0] x0, y0, x1, y1;

  vga_square_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_x(ix), .i_y(iy),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_commit(commit), .o_pending(pending), .o_committed(committed), .o_err(err),
    .o_x0(x0), .o_y0(y0), .o_x1(x1), .o_y1(y1), .o_square(square)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int kind; int exp; string name; } chk_t;
  typedef struct { bit is_err; int ex0; int ey0; int ex1; int ey1; string name; } ev_t;
  chk_t lq[$];
  ev_t  eq[$];
  int   checks = 0, failures = 0, cyc = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_sig(int k);
    case (k)
      K_SQ:   return int'(square);
      K_PEND: return int'(pending);
      K_RDY:  return int'(wr_ready);
      K_X0:   return int'(x0);
      K_Y0:   return int'(y0);
      K_X1:   return int'(x1);
      K_Y1:   return int'(y1);
      default: return -1;
    endcase
  endfunction

  // Monitor: pops due level checks and every committed/err pulse
  always @(negedge clk) begin
    for (int i = lq.size() - 1; i >= 0; i--) begin
      if (lq[i].due == cyc) begin
        checks++;
        if (get_sig(lq[i].kind) != lq[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d", lq[i].name, cyc, get_sig(lq[i].kind), lq[i].exp);
        end
        lq.delete(i);
      end
    end
    if (committed || err) begin
      checks++;
      if (eq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d committed=%0b err=%0b", cyc, committed, err);
      end else begin
        ev_t e;
        e = eq.pop_front();
        if (err != e.is_err || committed == e.is_err || int'(x0) != e.ex0 || int'(y0) != e.ey0 ||
            int'(x1) != e.ex1 || int'(y1) != e.ey1) begin
          failures++;
          $display("FAIL %s cyc=%0d got c=%0b e=%0b box=%0d/%0d/%0d/%0d want e=%0b box=%0d/%0d/%0d/%0d",
                   e.name, cyc, committed, err, x0, y0, x1, y1, e.is_err, e.ex0, e.ey0, e.ex1, e.ey1);
        end
      end
    end
    if (done || cyc > 3000) begin
      checks += 2;
      if (!done) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=running want=done", cyc);
      end
      if (lq.size() != 0) begin
        failures++;
        $display("FAIL level_queue_left got=%0d want=0", lq.size());
      end
      if (eq.size() != 0) begin
        failures++;
        $display("FAIL missing_pulses got=%0d want=0 next=%s", eq.size(), eq[0].name);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  task automatic exp_at(int lat, int k, int v, string n);
    lq.push_back('{cyc + lat, k, v, n});
  endtask

  task automatic exp_ev(bit e, int a, int b, int c, int d, string n);
    eq.push_back('{e, a, b, c, d, n});
  endtask

  task automatic wr(int a, int d);
    nxt();
    wr_valid = 1'b1;
    wr_addr  = 2'(a);
    wr_data  = CORDW'(d);
  endtask

  task automatic pix(int x, int y, int e, string n);
    nxt();
    ix = CORDW'(x);
    iy = CORDW'(y);
    exp_at(1, K_SQ, e, n);
  endtask

  initial begin
    rst = 1'b1; ix = '0; iy = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_at(0, K_RDY, 1, "rst_ready");   exp_at(0, K_PEND, 0, "rst_pending");
    exp_at(0, K_SQ, 0, "rst_square");   exp_at(0, K_X0, 220, "rst_x0");
    exp_at(0, K_Y0, 140, "rst_y0");     exp_at(0, K_X1, 420, "rst_x1");
    exp_at(0, K_Y1, 340, "rst_y1");

    pix(300, 200, 1, "sq_inside");
    pix(220, 200, 0, "sq_left_edge");
    pix(419, 339, 1, "sq_inner_corner");
    pix(420, 200, 0, "sq_right_edge");
    pix(300, 340, 0, "sq_bottom_edge");

    // Commit mid-frame waits for vblank
    wr(0, 10); wr(1, 10); wr(2, 50); wr(3, 50);
    nxt(); ix = 0; iy = 100; commit = 1'b1;
    exp_at(1, K_PEND, 1, "pend_set"); exp_at(1, K_RDY, 0, "pend_busy"); exp_at(1, K_X0, 220, "live_hold");
    nxt(); ix = 5; commit = 1'b1;
    exp_at(1, K_PEND, 1, "pend_recommit_ignored");
    pix(30, 30, 0, "sq_old_live");
    nxt(); ix = 0; iy = 480;
    exp_at(1, K_PEND, 0, "pend_clr"); exp_at(1, K_X0, 220, "live_vbl_edge");
    exp_at(2, K_X0, 10, "live_commit_x0"); exp_at(2, K_Y1, 50, "live_commit_y1");
    exp_at(2, K_RDY, 1, "ready_after_commit");
    exp_ev(1'b0, 10, 10, 50, 50, "commit_pulse");
    nxt(); ix = 1;
    pix(30, 30, 1, "sq_new_live");
    pix(50, 30, 0, "sq_new_edge");

    // Invalid shadow rejected
    wr(0, 60);
    nxt(); ix = 2; iy = 0; commit = 1'b1;
    exp_at(1, K_PEND, 0, "err_no_pend"); exp_at(1, K_RDY, 1, "err_ready");
    exp_ev(1'b1, 10, 10, 50, 50, "err_pulse");
    nxt(); exp_at(1, K_X0, 10, "err_live_hold");

    // Write while pending is not accepted
    wr(0, 20);
    nxt(); ix = 0; iy = 100; commit = 1'b1;
    exp_at(1, K_PEND, 1, "pend2_set");
    nxt(); wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 10'd5;
    exp_at(0, K_RDY, 0, "pend_not_ready");
    nxt(); ix = 0; iy = 480;
    exp_at(2, K_X0, 20, "pend_write_dropped");
    exp_ev(1'b0, 20, 10, 50, 50, "commit2_pulse");
    nxt(); ix = 1;

    // Commit presented on the vblank cycle itself
    wr(2, 60);
    nxt(); ix = 0; iy = 480; commit = 1'b1;
    exp_at(1, K_PEND, 0, "vbl_commit_no_pend"); exp_at(1, K_RDY, 0, "vbl_commit_busy");
    exp_at(2, K_X1, 60, "vbl_commit_live");
    exp_ev(1'b0, 20, 10, 60, 50, "vbl_commit_pulse");
    nxt(); ix = 1;

    // Write and commit together: validity uses post-write shadow
    nxt(); wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 10'd70; commit = 1'b1;
    exp_at(1, K_PEND, 0, "wrc_invalid");
    exp_ev(1'b1, 20, 10, 60, 50, "wrc_err_pulse");
    nxt(); wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 10'd30; commit = 1'b1;
    exp_at(1, K_PEND, 1, "wrc_valid_pend");
    nxt(); ix = 0; iy = 480;
    exp_at(2, K_X0, 30, "wrc_commit");
    exp_ev(1'b0, 30, 10, 60, 50, "wrc_commit_pulse");
    nxt(); ix = 1;

    // Reset while pending drops the commit and restores defaults
    wr(1, 40);
    nxt(); ix = 0; iy = 100; commit = 1'b1;
    exp_at(1, K_PEND, 1, "rst_pend_set");
    nxt(); rst = 1'b1;
    exp_at(1, K_PEND, 0, "rst_pend_clr"); exp_at(1, K_X0, 220, "rst_mid_x0");
    exp_at(1, K_Y0, 140, "rst_mid_y0");   exp_at(1, K_RDY, 1, "rst_mid_ready");
    nxt(); rst = 1'b0;
    nxt(); ix = 0; iy = 480;
`ifdef VGA_SQUARE_BOUNCE_EN
    exp_at(1, K_X0, 222, "bounce_idle_x0"); exp_at(1, K_Y1, 342, "bounce_idle_y1");
`else
    exp_at(1, K_X0, 220, "idle_vbl_x0"); exp_at(1, K_Y1, 340, "idle_vbl_y1");
`endif
    nxt(); ix = 1;
    nxt(); ix = 0; iy = 480; commit = 1'b1;
    exp_at(2, K_Y0, 140, "def_shadow_commit");
    exp_ev(1'b0, 220, 140, 420, 340, "def_commit_pulse");
    nxt(); ix = 1;

`ifdef VGA_SQUARE_BOUNCE_EN
    // Right edge reached: x flips in the same frame
    wr(0, 620); wr(1, 100); wr(2, 638); wr(3, 200);
    nxt(); ix = 0; iy = 480; commit = 1'b1;
    exp_ev(1'b0, 620, 100, 638, 200, "bounce_commit_pulse");
    nxt(); ix = 1;
    nxt(); ix = 2;
    nxt(); ix = 0; iy = 480;
    exp_at(1, K_X0, 618, "bounce_flip_x0"); exp_at(1, K_X1, 636, "bounce_flip_x1");
    exp_at(1, K_Y0, 102, "bounce_y0");      exp_at(1, K_Y1, 202, "bounce_y1");
    nxt(); ix = 1;
    nxt(); ix = 0; iy = 480;
    exp_at(1, K_X0, 616, "bounce_neg_x0");  exp_at(1, K_Y1, 204, "bounce_pos_y1");
    nxt(); ix = 1;
`endif

    nxt(); nxt(); nxt();
    done = 1'b1;
  end
endmodule
